// File: rtl/updown_counter_nbit.sv
// Parameterised up/down counter with prescaler, bounded range, wrap or clamp at the limits.
// Count updates one cycle after a step/load/clear; no backpressure, enable is the only qualifier.
module updown_counter_nbit #(
  parameter int WIDTH     = 10,
  parameter int STEP      = 1,
  parameter int MIN_VALUE = 0,
  parameter int MAX_VALUE = (2**WIDTH)-1,
  parameter int SATURATE  = 0,
  parameter int PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             enable,
  input  logic             up,
  output logic [WIDTH-1:0] countValue,
  output logic             atMax,
  output logic             atMin,
  output logic             limitPulse
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH:0]   MIN_X    = (WIDTH+1)'(MIN_VALUE);
  localparam logic [WIDTH:0]   MAX_X    = (WIDTH+1)'(MAX_VALUE);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MIN_N    = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_N    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(STEP);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE-1);

  logic [PW-1:0]    pre_cnt;
  logic             step;
  logic             up_ok;
  logic             dn_ok;
  logic             step_limit;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;

  // Range checks use one extra bit so count+STEP cannot overflow before the compare.
  assign up_ok = (({1'b0, countValue} + STEP_X) <= MAX_X);
  assign dn_ok = ({1'b0, countValue} >= (MIN_X + STEP_X));
  assign step  = enable && (pre_cnt == PRE_LAST);

  assign atMax = ({1'b0, countValue} == MAX_X);
  assign atMin = ({1'b0, countValue} == MIN_X);

  always_comb begin
    step_val   = countValue;
    step_limit = 1'b0;
    if (up) begin
      if (up_ok) begin
        step_val = countValue + STEP_N;
      end else begin
        step_limit = 1'b1;
        step_val   = (SATURATE != 0) ? MAX_N : MIN_N;
      end
    end else begin
      if (dn_ok) begin
        step_val = countValue - STEP_N;
      end else begin
        step_limit = 1'b1;
        step_val   = (SATURATE != 0) ? MIN_N : MAX_N;
      end
    end
  end

  always_comb begin
    load_val = loadValue;
    if ({1'b0, loadValue} > MAX_X) begin
      load_val = MAX_N;
    end else if ({1'b0, loadValue} < MIN_X) begin
      load_val = MIN_N;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      countValue <= MIN_N;
      pre_cnt    <= '0;
      limitPulse <= 1'b0;
    end else begin
      limitPulse <= 1'b0;
      if (clear) begin
        countValue <= MIN_N;
        pre_cnt    <= '0;
      end else if (load) begin
        countValue <= load_val;
        pre_cnt    <= '0;
      end else if (enable) begin
        if (step) begin
          countValue <= step_val;
          pre_cnt    <= '0;
          limitPulse <= step_limit;
        end else begin
          pre_cnt <= pre_cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter_nbit.sv
// Directed bench for updown_counter_nbit: three instances (wrap, saturate, no prescale) share stimulus.
module tb_updown_counter_nbit;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       load;
  logic [3:0] loadValue;
  logic       enable;
  logic       up;

  logic [3:0] c0, c1, c2;
  logic       mx0, mn0, lp0;
  logic       mx1, mn1, lp1;
  logic       mx2, mn2, lp2;

  int tests_run    = 0;
  int tests_failed = 0;

  updown_counter_nbit #(.WIDTH(4), .STEP(3), .MIN_VALUE(2), .MAX_VALUE(11),
                        .SATURATE(0), .PRESCALE(2)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .loadValue(loadValue),
    .enable(enable), .up(up), .countValue(c0), .atMax(mx0), .atMin(mn0), .limitPulse(lp0));

  updown_counter_nbit #(.WIDTH(4), .STEP(3), .MIN_VALUE(2), .MAX_VALUE(11),
                        .SATURATE(1), .PRESCALE(2)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .loadValue(loadValue),
    .enable(enable), .up(up), .countValue(c1), .atMax(mx1), .atMin(mn1), .limitPulse(lp1));

  updown_counter_nbit #(.WIDTH(4), .STEP(1), .MIN_VALUE(2), .MAX_VALUE(11),
                        .SATURATE(0), .PRESCALE(1)) u_fast (
    .clock(clock), .reset(reset), .clear(clear), .load(load), .loadValue(loadValue),
    .enable(enable), .up(up), .countValue(c2), .atMax(mx2), .atMin(mn2), .limitPulse(lp2));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int exp_cnt[8]   = '{2, 5, 5, 8, 8, 11, 11, 2};
  int exp_pulse[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    reset = 1'b0; clear = 1'b0; load = 1'b0; loadValue = 4'd0; enable = 1'b0; up = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_count", c0, 2);
    check("rst_pulse", lp0, 0);
    check("rst_atmin", mn0, 1);
    check("rst_atmax", mx0, 0);

    // Inputs must be ignored while reset is held across an edge
    enable = 1'b1; up = 1'b1; load = 1'b1; loadValue = 4'd7;
    tick();
    check("rst_hold_count", c0, 2);
    reset = 1'b0; load = 1'b0; enable = 1'b0;

    // Scenario 1: prescaled up-count with wrap
    check("s1_start", c0, 2);
    enable = 1'b1; up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("s1_count_%0d", i), c0, exp_cnt[i]);
      check($sformatf("s1_pulse_%0d", i), lp0, exp_pulse[i]);
      if (i == 5) check("s1_atmax", mx0, 1);
    end
    tick();
    check("s1_after_count", c0, 2);
    check("s1_after_pulse", lp0, 0);

    // Scenario 2: saturating down-count
    enable = 1'b0; load = 1'b1; loadValue = 4'd4;
    tick();
    check("s2_load", c1, 4);
    load = 1'b0; enable = 1'b1; up = 1'b0;
    tick();
    check("s2_hold", c1, 4);
    check("s2_hold_pulse", lp1, 0);
    tick();
    check("s2_clamp", c1, 2);
    check("s2_clamp_pulse", lp1, 1);
    tick();
    check("s2_mid_pulse", lp1, 0);
    tick();
    check("s2_reclamp", c1, 2);
    check("s2_reclamp_pulse", lp1, 1);
    check("s2_atmin", mn1, 1);

    // Scenario 3: load clamping
    enable = 1'b0; load = 1'b1; loadValue = 4'd13;
    tick();
    check("s3_load13", c0, 11);
    check("s3_atmax", mx0, 1);
    loadValue = 4'd0;
    tick();
    check("s3_load0", c0, 2);
    loadValue = 4'd7;
    tick();
    check("s3_load7", c0, 7);
    check("s3_load_pulse", lp0, 0);
    load = 1'b0;

    // Scenario 4: clear beats load; load restarts the prescaler
    clear = 1'b1; load = 1'b1; loadValue = 4'd9;
    tick();
    check("s4_clear_wins", c0, 2);
    clear = 1'b0; load = 1'b0; enable = 1'b1; up = 1'b1;
    tick();
    check("s4_pre_armed", c0, 2);
    load = 1'b1; loadValue = 4'd5;
    tick();
    check("s4_load_no_step", c0, 5);
    load = 1'b0;
    tick();
    check("s4_prescale_restart", c0, 5);
    tick();
    check("s4_first_step", c0, 8);

    // Scenario 5: asynchronous reset between edges
    enable = 1'b0;
    #3 reset = 1'b1;
    #1;
    check("s5_async_count", c0, 2);
    check("s5_async_pulse", lp0, 0);
    #1 reset = 1'b0;
    enable = 1'b1; up = 1'b1;
    tick();
    check("s5_resume_pre", c0, 2);
    tick();
    check("s5_resume_step", c0, 5);

    // Scenario 6: PRESCALE=1, STEP=1 with gated enable
    enable = 1'b0; load = 1'b1; loadValue = 4'd2;
    tick();
    load = 1'b0;
    check("s6_start", c2, 2);
    enable = 1'b1; tick(); check("s6_en1", c2, 3);
    enable = 1'b0; tick(); check("s6_en0", c2, 3);
    enable = 1'b1; tick(); check("s6_en1b", c2, 4);
    enable = 1'b0; tick(); check("s6_en0b", c2, 4);
    up = 1'b0; tick(); check("s6_dir_idle0", c2, 4);
    up = 1'b1; tick(); check("s6_dir_idle1", c2, 4);
    up = 1'b0; enable = 1'b1; tick(); check("s6_down", c2, 3);

    // Wrap in both directions on the unprescaled instance
    enable = 1'b0; load = 1'b1; loadValue = 4'd11;
    tick();
    check("s6_load11_atmax", mx2, 1);
    load = 1'b0; enable = 1'b1; up = 1'b1;
    tick();
    check("s6_wrap_up", c2, 2);
    check("s6_wrap_up_pulse", lp2, 1);
    up = 1'b0;
    tick();
    check("s6_wrap_dn", c2, 11);
    check("s6_wrap_dn_pulse", lp2, 1);
    enable = 1'b0;
    tick();
    check("s6_idle_pulse", lp2, 0);
    check("s6_idle_count", c2, 11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/updown_counter_nbit.md
UPDOWN_COUNTER_NBIT -- requirements
Module: updown_counter_nbit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 10: counter width in bits.
REQ-002 The block SHALL take parameter STEP, default 1: amount added or subtracted per step.
REQ-003 The block SHALL take parameter MIN_VALUE, default 0: lower count bound.
REQ-004 The block SHALL take parameter MAX_VALUE, default (2**WIDTH)-1: upper count bound.
REQ-005 The block SHALL take parameter SATURATE, default 0: 0 = wrap at bounds, 1 = clamp at bounds.
REQ-006 The block SHALL take parameter PRESCALE, default 1: number of enabled cycles per step.
REQ-007 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-008 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous return to MIN_VALUE.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load of loadValue.
REQ-011 The block SHALL have port loadValue, input, WIDTH bits: value to load.
REQ-012 The block SHALL have port enable, input, 1 bit: counting qualifier.
REQ-013 The block SHALL have port up, input, 1 bit: direction, 1 = up, 0 = down.
REQ-014 The block SHALL have port countValue, output, WIDTH bits: registered count.
REQ-015 The block SHALL have port atMax, output, 1 bit: high when countValue == MAX_VALUE; combinational from the register.
REQ-016 The block SHALL have port atMin, output, 1 bit: high when countValue == MIN_VALUE; combinational from the register.
REQ-017 The block SHALL have port limitPulse, output, 1 bit: registered one-cycle flag for a step that wrapped or clamped.

Function
REQ-018 Legal parameters SHALL satisfy MIN_VALUE < MAX_VALUE <= 2**WIDTH-1, 1 <= STEP <= MAX_VALUE-MIN_VALUE, and PRESCALE >= 1; other values are unsupported.
REQ-019 Per-edge priority SHALL be: clear, then load, then step.
REQ-020 An internal prescale counter SHALL increment on each enabled cycle and zero on clear, load or reset.
REQ-021 A step SHALL occur on a cycle with enable=1 and prescale counter == PRESCALE-1; that step SHALL also zero the prescale counter.
REQ-022 With PRESCALE=1, every enabled cycle SHALL be a step.
REQ-023 All bound arithmetic SHALL be done in WIDTH+1 bits, so that no intermediate overflow or underflow occurs.
REQ-024 On an up step where countValue+STEP <= MAX_VALUE, the next value SHALL be countValue+STEP; otherwise it SHALL be MIN_VALUE (SATURATE=0) or MAX_VALUE (SATURATE=1).
REQ-025 On a down step where countValue >= MIN_VALUE+STEP, the next value SHALL be countValue-STEP; otherwise it SHALL be MAX_VALUE (SATURATE=0) or MIN_VALUE (SATURATE=1).
REQ-026 limitPulse SHALL be 1 in the cycle after any step that took the out-of-range branch of REQ-024 or REQ-025, including clamped steps while already at a bound; otherwise it SHALL be 0.
REQ-027 A load SHALL store loadValue clamped to [MIN_VALUE, MAX_VALUE]: values above MAX_VALUE store MAX_VALUE, values below MIN_VALUE store MIN_VALUE.
REQ-028 A cycle containing clear or load SHALL NOT step, and SHALL drive limitPulse to 0 on the next cycle.
REQ-029 The direction input up SHALL be sampled only on step cycles; toggling it between steps SHALL have no effect.
REQ-030 With enable=0, countValue and the prescale counter SHALL hold.

Reset
REQ-031 When reset is asserted, countValue SHALL become MIN_VALUE, the prescale counter 0 and limitPulse 0, immediately and independent of clock.
REQ-032 While reset is held high, all inputs SHALL be ignored.
REQ-033 Counting SHALL resume on the first rising edge after reset deasserts.

Verification
(All scenarios use WIDTH=4, MIN_VALUE=2, MAX_VALUE=11, STEP=3, PRESCALE=2 unless noted.)
REQ-034 Scenario 1: reset, then enable=1, up=1 held for 8 cycles -> countValue 2,2,5,5,8,8,11,11, then 2 with limitPulse=1 for one cycle (SATURATE=0).
REQ-035 Scenario 2: SATURATE=1, load 4, then enable=1, up=0 -> countValue 4 until the step, then 2 with limitPulse=1; the next step holds 2 with limitPulse=1 again; atMin=1.
REQ-036 Scenario 3: load with loadValue=13 -> countValue 11 and atMax=1; load with loadValue=0 -> countValue 2; load with loadValue=7 -> countValue 7.
REQ-037 Scenario 4: clear and load with loadValue=9 in the same cycle -> countValue 2; load with enable=1 in the same cycle -> loaded value, no step, and the prescale restarts so the first step comes 2 enabled cycles later.
REQ-038 Scenario 5: reset pulsed asynchronously between edges mid-count at countValue=8 -> countValue 2 and limitPulse 0 before the next edge.
REQ-039 Scenario 6: PRESCALE=1, STEP=1, enable toggling 1,0,1,0 with up=1 from 2 -> countValue 3,3,4,4; toggling up on the disabled cycles -> no change.
